// File: rtl/regarray_pkg.sv
// Shared types and constants for the register-array arbiter.
package regarray_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } arbState_t;

   localparam int CONFLICT_W = 16;

endpackage

// File: rtl/regarray_arbiter.sv
// Owns both ports of a registerArray: zeroing sweep after reset or clr_req,
// round-robin arbitration of two writers, and one-cycle-latency reads.
module regarray_arbiter
   import regarray_pkg::*;
#(
   parameter int DEPTH     = 64,
   parameter int LOGDEPTH  = 6,
   parameter int WORDWIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_req,
   output logic                  init_busy,
   input  logic                  wr0_req,
   input  logic [LOGDEPTH-1:0]   wr0_addr,
   input  logic [WORDWIDTH-1:0]  wr0_data,
   output logic                  wr0_gnt,
   input  logic                  wr1_req,
   input  logic [LOGDEPTH-1:0]   wr1_addr,
   input  logic [WORDWIDTH-1:0]  wr1_data,
   output logic                  wr1_gnt,
   input  logic                  rd_req,
   input  logic [LOGDEPTH-1:0]   rd_addr,
   output logic                  rd_gnt,
   output logic                  rd_valid,
   output logic [WORDWIDTH-1:0]  rd_data,
   output logic [LOGDEPTH-1:0]   mem_aA,
   output logic                  mem_cenA,
   input  logic [WORDWIDTH-1:0]  mem_q,
   output logic [LOGDEPTH-1:0]   mem_aB,
   output logic                  mem_cenB,
   output logic [WORDWIDTH-1:0]  mem_d,
   output logic [CONFLICT_W-1:0] wr_conflicts
);

   arbState_t           state;
   logic [LOGDEPTH-1:0] cnt;
   logic                rr;
   logic                inRun;
   logic                bothReq;
   logic                sweepDone;

   assign inRun     = (state == RUN);
   assign bothReq   = wr0_req & wr1_req;
   assign sweepDone = (cnt == LOGDEPTH'(DEPTH - 1));
   assign init_busy = ~inRun;

   // rr names the favoured writer when both request; a lone requester always wins.
   assign wr0_gnt = inRun & ~clr_req & wr0_req & (~wr1_req | ~rr);
   assign wr1_gnt = inRun & ~clr_req & wr1_req & (~wr0_req | rr);

   assign rd_gnt   = inRun & rd_req;
   assign mem_cenA = ~rd_gnt;
   assign mem_aA   = inRun ? rd_addr : '0;
   assign rd_data  = mem_q;

   // Write port is owned by the sweep in INIT and by the granted writer in RUN.
   always_comb begin
      mem_cenB = 1'b1;
      mem_aB   = '0;
      mem_d    = '0;
      if (!inRun) begin
         mem_cenB = 1'b0;
         mem_aB   = cnt;
      end else if (wr0_gnt) begin
         mem_cenB = 1'b0;
         mem_aB   = wr0_addr;
         mem_d    = wr0_data;
      end else if (wr1_gnt) begin
         mem_cenB = 1'b0;
         mem_aB   = wr1_addr;
         mem_d    = wr1_data;
      end
   end

   // Sweep counter and state; clr_req only matters once the sweep is finished.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= INIT;
         cnt   <= '0;
      end else if (!inRun) begin
         cnt <= cnt + 1'b1;
         if (sweepDone) begin
            state <= RUN;
         end
      end else if (clr_req) begin
         state <= INIT;
         cnt   <= '0;
      end
   end

   // After any grant the pointer favours the writer that lost out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr <= 1'b0;
      end else if (wr0_gnt) begin
         rr <= 1'b1;
      end else if (wr1_gnt) begin
         rr <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_gnt;
      end
   end

   // Contention counter survives clears and sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_conflicts <= '0;
      end else if (inRun && bothReq && (wr_conflicts != '1)) begin
         wr_conflicts <= wr_conflicts + 1'b1;
      end
   end

endmodule

// File: tb/tb_regarray_arbiter.sv
// Bench for regarray_arbiter: behavioural array, reference model of expected
// contents/arbitration, directed scenarios plus randomized traffic.
module tb_regarray_arbiter;

   localparam int DEPTH     = 64;
   localparam int LOGDEPTH  = 6;
   localparam int WORDWIDTH = 16;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 clr_req;
   logic                 init_busy;
   logic                 wr0_req, wr1_req;
   logic [LOGDEPTH-1:0]  wr0_addr, wr1_addr;
   logic [WORDWIDTH-1:0] wr0_data, wr1_data;
   logic                 wr0_gnt, wr1_gnt;
   logic                 rd_req;
   logic [LOGDEPTH-1:0]  rd_addr;
   logic                 rd_gnt;
   logic                 rd_valid;
   logic [WORDWIDTH-1:0] rd_data;
   logic [LOGDEPTH-1:0]  mem_aA, mem_aB;
   logic                 mem_cenA, mem_cenB;
   logic [WORDWIDTH-1:0] mem_q, mem_d;
   logic [15:0]          wr_conflicts;

   int vectors    = 0;
   int miscompares = 0;

   logic [WORDWIDTH-1:0] arrayStore [DEPTH];
   logic [WORDWIDTH-1:0] refMem [DEPTH];
   int                   favour;
   int                   conf;
   int                   busyLeft;
   logic                 pendValid;
   logic [WORDWIDTH-1:0] pendData;

   always #5 clk = ~clk;

   regarray_arbiter #(
      .DEPTH(DEPTH), .LOGDEPTH(LOGDEPTH), .WORDWIDTH(WORDWIDTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .init_busy(init_busy),
      .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
      .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .mem_aA(mem_aA), .mem_cenA(mem_cenA), .mem_q(mem_q),
      .mem_aB(mem_aB), .mem_cenB(mem_cenB), .mem_d(mem_d),
      .wr_conflicts(wr_conflicts)
   );

   // Stand-in for the registerArray: synchronous read port A, write port B.
   always @(posedge clk) begin
      if (!mem_cenB) arrayStore[mem_aB] <= mem_d;
      if (!mem_cenA) mem_q <= arrayStore[mem_aA];
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      busyLeft  = DEPTH;
      favour    = 0;
      conf      = 0;
      pendValid = 1'b0;
      pendData  = '0;
      for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
   endtask

   // One clock cycle: check registered outputs, drive inputs, check the
   // combinational response against the model, then advance the model.
   task automatic applyStimulus(
      input logic w0, input logic [LOGDEPTH-1:0] a0, input logic [WORDWIDTH-1:0] d0,
      input logic w1, input logic [LOGDEPTH-1:0] a1, input logic [WORDWIDTH-1:0] d1,
      input logic rd, input logic [LOGDEPTH-1:0] ra, input logic clr);
      int winner;
      checkOutput("rd_valid", rd_valid, pendValid);
      if (pendValid) checkOutput("rd_data", rd_data, pendData);
      checkOutput("wr_conflicts", wr_conflicts, conf);
      wr0_req = w0; wr0_addr = a0; wr0_data = d0;
      wr1_req = w1; wr1_addr = a1; wr1_data = d1;
      rd_req = rd; rd_addr = ra; clr_req = clr;
      #1;
      if (busyLeft > 0) begin
         checkOutput("init_busy", init_busy, 1);
         checkOutput("gnt0_init", wr0_gnt, 0);
         checkOutput("gnt1_init", wr1_gnt, 0);
         checkOutput("rd_gnt_init", rd_gnt, 0);
         checkOutput("cenA_init", mem_cenA, 1);
         checkOutput("sweep_cen", mem_cenB, 0);
         checkOutput("sweep_addr", mem_aB, DEPTH - busyLeft);
         checkOutput("sweep_data", mem_d, 0);
         busyLeft--;
         pendValid = 1'b0;
      end else begin
         winner = -1;
         if (!clr) begin
            if (w0 && w1) winner = favour;
            else if (w0) winner = 0;
            else if (w1) winner = 1;
         end
         if (w0 && w1 && conf < 65535) conf++;
         checkOutput("init_busy", init_busy, 0);
         checkOutput("gnt0", wr0_gnt, winner == 0);
         checkOutput("gnt1", wr1_gnt, winner == 1);
         checkOutput("cenB", mem_cenB, winner < 0);
         checkOutput("aB", mem_aB, (winner == 0) ? a0 : (winner == 1) ? a1 : 0);
         checkOutput("d", mem_d, (winner == 0) ? d0 : (winner == 1) ? d1 : 0);
         checkOutput("rd_gnt", rd_gnt, rd);
         checkOutput("cenA", mem_cenA, !rd);
         if (rd) checkOutput("aA", mem_aA, ra);
         pendValid = rd;
         pendData  = refMem[ra];
         if (winner == 0) refMem[a0] = d0;
         if (winner == 1) refMem[a1] = d1;
         if (winner >= 0) favour = 1 - winner;
         if (clr) begin
            busyLeft = DEPTH;
            for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic readAt(input logic [LOGDEPTH-1:0] ra);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, ra, 0);
   endtask

   task automatic randomTraffic(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 16'($urandom),
                       1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 16'($urandom),
                       1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                       $urandom_range(0, 63) == 0);
      end
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      wr0_req = 1'b1; wr0_addr = '0; wr0_data = '0;
      wr1_req = 1'b1; wr1_addr = '0; wr1_data = '0;
      rd_req = 1'b1; rd_addr = '0; clr_req = 1'b0;
      #1;
      checkOutput("rst_init_busy", init_busy, 1);
      checkOutput("rst_rd_valid", rd_valid, 0);
      checkOutput("rst_conflicts", wr_conflicts, 0);
      checkOutput("rst_gnt0", wr0_gnt, 0);
      checkOutput("rst_gnt1", wr1_gnt, 0);
      checkOutput("rst_rd_gnt", rd_gnt, 0);
      wr0_req = 1'b0; wr1_req = 1'b0; rd_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();

      idleCycles(DEPTH);
      readAt(37);
      idleCycles(1);

      // Both writers contend for six cycles; grants must alternate from writer 0.
      for (int n = 0; n < 6; n++) begin
         applyStimulus(1, 6'(n), 16'hA000 + 16'(n), 1, 6'(8 + n), 16'hB000 + 16'(n), 0, 0, 0);
      end
      for (int n = 0; n < 6; n++) readAt(6'(n));
      idleCycles(1);

      applyStimulus(1, 5, 16'h1234, 0, 0, 0, 0, 0, 0);
      readAt(5);
      idleCycles(1);

      applyStimulus(1, 9, 16'h0001, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 9, 16'h0002, 0, 0, 0, 1, 9, 0);
      readAt(9);
      idleCycles(1);

      randomTraffic(400);
      idleCycles(DEPTH);

      // Clear while both writers request and a read is in flight.
      for (int n = 0; n < 4; n++) applyStimulus(1, 6'(20 + n), 16'hC000 + 16'(n), 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 20, 16'hDEAD, 1, 21, 16'hBEEF, 1, 22, 1);
      idleCycles(DEPTH);
      for (int n = 0; n < 4; n++) readAt(6'(20 + n));
      idleCycles(1);

      // Reset during traffic: rd_valid must drop without waiting for a clock.
      readAt(3);
      checkOutput("pre_rst_valid", rd_valid, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("async_rd_valid", rd_valid, 0);
      checkOutput("async_init_busy", init_busy, 1);
      checkOutput("async_conflicts", wr_conflicts, 0);
      checkOutput("async_aB", mem_aB, 0);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      idleCycles(20);

      // Reset at sweep cycle 20: the sweep restarts from address 0.
      rst_n = 1'b0;
      #1;
      checkOutput("midsweep_aB", mem_aB, 0);
      checkOutput("midsweep_busy", init_busy, 1);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      idleCycles(DEPTH);
      applyStimulus(1, 1, 16'h0F0F, 1, 2, 16'hF0F0, 0, 0, 0);
      randomTraffic(150);
      idleCycles(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regarray_arbiter.md
# regarray_arbiter

Single-clock controller that owns both ports of a `registerArray` instance and shares them between two write requesters and one read requester. After reset, or on request, it sweeps the array to zero. It then grants writes round-robin and issues reads with a fixed one-cycle latency. It sits between client logic and the array; the array's `clkA`/`clkB` are both tied to `clk` at the parent.

## Interface
- `DEPTH`, 64, number of words; must equal 2**`LOGDEPTH`
- `LOGDEPTH`, 6, address width
- `WORDWIDTH`, 16, data width
- `clk`  in  1  single clock; all logic on posedge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `clr_req`  in  1  one-cycle pulse that starts a zeroing sweep
- `init_busy`  out  1  high while a sweep is running
- `wr0_req`, `wr1_req`  in  1  write request, requester 0/1
- `wr0_addr`, `wr1_addr`  in  LOGDEPTH  write address
- `wr0_data`, `wr1_data`  in  WORDWIDTH  write data
- `wr0_gnt`, `wr1_gnt`  out  1  write grant, combinational
- `rd_req`  in  1  read request
- `rd_addr`  in  LOGDEPTH  read address
- `rd_gnt`  out  1  read grant, combinational
- `rd_valid`  out  1  read data valid, registered
- `rd_data`  out  WORDWIDTH  read data; driven from `mem_q`
- `mem_aA`, `mem_cenA`  out  LOGDEPTH/1  array read port; cen is active-low
- `mem_q`  in  WORDWIDTH  array output bus
- `mem_aB`, `mem_cenB`, `mem_d`  out  LOGDEPTH/1/WORDWIDTH  array write port
- `wr_conflicts`  out  16  saturating count of cycles where both writers request

## Operation
- The FSM has two states, `INIT` and `RUN`. Reset enters `INIT` with sweep counter `cnt`=0.
- **`INIT` state**
  - Each cycle: `mem_cenB`=0, `mem_aB`=`cnt`, `mem_d`=0, `cnt`++.
  - When `cnt`==DEPTH-1 the FSM moves to `RUN` on the same edge as that final write.
  - All grants are 0. `mem_cenA`=1. `init_busy`=1.
  - `clr_req` is ignored during `INIT`.
- **`RUN` state, writes**
  - If only one writer requests, it is granted.
  - If both request, the writer indicated by priority pointer `rr` is granted. `rr` then points to the other writer.
  - After any single grant, `rr` points to the writer that was not granted.
  - The transfer occurs on the edge where `req` and `gnt` are both high. Ungranted requesters hold their request.
- **`RUN` state, reads**
  - `rd_gnt` = `rd_req`. `mem_cenA` = ~`rd_req`. `mem_aA` = `rd_addr`.
- **`RUN` state, clear**
  - When `clr_req` is high, all grants are 0 that cycle. The next state is `INIT` with `cnt`=0.
- **Read/write to the same address on the same edge:** the read returns the old word. This is the array's inherent behaviour; the controller adds no forwarding.
- **`wr_conflicts`**
  - Increments in `RUN` on every cycle where both writers request, including cycles where `clr_req` is high.
  - Saturates at 0xFFFF. It is not cleared by `clr_req`.
- **Idle write port:** when no write is granted, `mem_cenB`=1 and `mem_aB`/`mem_d` are don't-care (drive 0).

## Timing
- **Reset values:** `rd_valid`=0, `init_busy`=1, `rr`=0 (writer 0 favoured), `wr_conflicts`=0, all grants 0.
- **Sweep length:** a sweep lasts exactly DEPTH cycles. `init_busy` falls on the edge after the final zero write. The first grant is possible in cycle DEPTH after reset release.
- **Write latency:** data is in the array at the granting edge. A read issued in the following cycle returns it.
- **Read latency:** `rd_valid` is high exactly one cycle after an `rd_req`/`rd_gnt` cycle, and `rd_data` is valid in that cycle. Back-to-back reads give one result per cycle.
- **Reset during a sweep or during traffic:** the FSM returns asynchronously to `INIT` with `cnt`=0 and `rd_valid` drops immediately. Array contents are undefined until the new sweep finishes.
- **`clr_req` on a read cycle:** the read is still granted, and `rd_valid` follows in the first `INIT` cycle.

## Structure
- Package `regarray_pkg`:
  - state enum `{INIT, RUN}`
  - `CONFLICT_W`=16
- No sub-module. The `registerArray` instance lives in the parent, not here.

## Test plan
- **Reset sweep.** Release `rst_n` with DEPTH=64. Required: `mem_cenB`=0 for 64 cycles at addresses 0..63 with `mem_d`=0, and `init_busy` falls on cycle 64. Then a read at address 37 returns 0x0000.
- **Write contention.** Both writers request every cycle for 6 cycles, with writer 0 writing 0xA000+n and writer 1 writing 0xB000+n. Required: grants alternate 0,1,0,1,0,1 and `wr_conflicts`=6.
- **Read latency.** Write 0x1234 to address 5, then read address 5 the next cycle. Required: `rd_valid`=1 with `rd_data`=0x1234 one cycle later.
- **Same-cycle read and write.** Address 9 holds 0x0001; writer 0 writes 0x0002 to address 9 in the same cycle a read of address 9 is issued. Required: the read returns 0x0001, and a read the following cycle returns 0x0002.
- **Clear mid-traffic.** Pulse `clr_req` while both writers request. Required: no grant that cycle, `init_busy`=1 for 64 cycles, previously written words read back as 0, and `wr_conflicts` is retained.
- **Reset mid-sweep.** Assert `rst_n` low at sweep cycle 20. Required: outputs go to their reset values asynchronously, and a fresh 64-cycle sweep restarts from address 0.
